// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives the instruction-memory request and registers IF/ID.
// Redirects from EX override stalls, and a word that returns during a stall is kept in a hold buffer.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_pc_write,
    input  logic        i_if_id_write,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_if_id_pc,
    output logic [31:0] o_if_id_instruction,
    output logic        o_if_id_valid
);

    typedef enum logic [1:0] {
        WAIT_RST = 2'd0,
        FETCH    = 2'd1,
        BUF_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic        req_q, req_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        if_valid_q, if_valid_d;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_pc;
    logic        advance;

    assign pc_plus4    = pc_q + 32'd4;
    assign redirect_pc = i_branch_target & ~32'd3;
    assign advance     = i_pc_write && i_if_id_write;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        buf_d      = buf_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        if_valid_d = if_valid_q;

        // A redirect wins over everything, including a word returning this cycle.
        if (i_branch_taken) begin
            state_d    = FETCH;
            pc_d       = redirect_pc;
            buf_d      = 32'd0;
            if_pc_d    = redirect_pc;
            if_instr_d = NOP_INSTR;
            if_valid_d = 1'b0;
        end else begin
            case (state_q)
                WAIT_RST: begin
                    state_d = FETCH;
                end
                FETCH: begin
                    if (i_imem_ready && advance) begin
                        pc_d       = pc_plus4;
                        if_pc_d    = pc_q;
                        if_instr_d = i_imem_rdata;
                        if_valid_d = 1'b1;
                    end else begin
                        if (i_imem_ready) begin
                            buf_d   = i_imem_rdata;
                            state_d = BUF_HOLD;
                        end
                        if (i_if_id_write) begin
                            if_pc_d    = pc_q;
                            if_instr_d = NOP_INSTR;
                            if_valid_d = 1'b0;
                        end
                    end
                end
                BUF_HOLD: begin
                    if (advance) begin
                        state_d    = FETCH;
                        pc_d       = pc_plus4;
                        if_pc_d    = pc_q;
                        if_instr_d = buf_q;
                        if_valid_d = 1'b1;
                    end else if (i_if_id_write) begin
                        if_pc_d    = pc_q;
                        if_instr_d = NOP_INSTR;
                        if_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = WAIT_RST;
                end
            endcase
        end

        req_d = (state_d == FETCH);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= WAIT_RST;
            pc_q       <= RESET_PC;
            buf_q      <= 32'd0;
            req_q      <= 1'b0;
            if_pc_q    <= 32'd0;
            if_instr_q <= NOP_INSTR;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            buf_q      <= buf_d;
            req_q      <= req_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            if_valid_q <= if_valid_d;
        end
    end

    assign o_imem_req          = req_q;
    assign o_imem_addr         = pc_q;
    assign o_if_id_pc          = if_pc_q;
    assign o_if_id_instruction = if_instr_q;
    assign o_if_id_valid       = if_valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a word-level reference model checked every cycle,
// plus directed vectors with hand-computed IF/ID and address expectations.
module tb_instruction_fetch;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] KEY  = 32'hA5A5_0000;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_pc_write;
    logic        i_if_id_write;
    logic        i_branch_taken;
    logic [31:0] i_branch_target;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ready;
    logic [31:0] i_imem_rdata;
    logic [31:0] o_if_id_pc;
    logic [31:0] o_if_id_instruction;
    logic        o_if_id_valid;

    int n_checks = 0;
    int n_fails  = 0;

    instruction_fetch #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP)
    ) dut (
        .i_clk              (i_clk),
        .i_reset            (i_reset),
        .i_pc_write         (i_pc_write),
        .i_if_id_write      (i_if_id_write),
        .i_branch_taken     (i_branch_taken),
        .i_branch_target    (i_branch_target),
        .o_imem_req         (o_imem_req),
        .o_imem_addr        (o_imem_addr),
        .i_imem_ready       (i_imem_ready),
        .i_imem_rdata       (i_imem_rdata),
        .o_if_id_pc         (o_if_id_pc),
        .o_if_id_instruction(o_if_id_instruction),
        .o_if_id_valid      (o_if_id_valid)
    );

    always #5 i_clk = ~i_clk;

    // Memory returns addr^KEY when ready and junk otherwise, so a stale buffer is visible.
    assign i_imem_rdata = i_imem_ready ? (o_imem_addr ^ KEY) : JUNK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks whether fetching has started, whether a returned word is
    // waiting for the pipeline, the fetch address, and what IF/ID must show.
    logic        m_run, m_held;
    logic [31:0] m_word, m_pc, m_ifpc, m_ifi;
    logic        m_ifv;

    always @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            m_run  <= 1'b0;
            m_held <= 1'b0;
            m_word <= 32'd0;
            m_pc   <= 32'd0;
            m_ifpc <= 32'd0;
            m_ifi  <= NOP;
            m_ifv  <= 1'b0;
        end else if (i_branch_taken) begin
            m_run  <= 1'b1;
            m_held <= 1'b0;
            m_pc   <= {i_branch_target[31:2], 2'b00};
            m_ifpc <= {i_branch_target[31:2], 2'b00};
            m_ifi  <= NOP;
            m_ifv  <= 1'b0;
        end else if (!m_run) begin
            m_run <= 1'b1;
        end else if ((m_held || i_imem_ready) && i_pc_write && i_if_id_write) begin
            m_ifpc <= m_pc;
            m_ifi  <= m_held ? m_word : (m_pc ^ KEY);
            m_ifv  <= 1'b1;
            m_pc   <= m_pc + 32'd4;
            m_held <= 1'b0;
        end else begin
            if (!m_held && i_imem_ready) begin
                m_held <= 1'b1;
                m_word <= m_pc ^ KEY;
            end
            if (i_if_id_write) begin
                m_ifpc <= m_pc;
                m_ifi  <= NOP;
                m_ifv  <= 1'b0;
            end
        end
    end

    always @(negedge i_clk) begin
        if (!i_reset) begin
            check("model_req",   {31'd0, o_imem_req},    {31'd0, m_run && !m_held});
            check("model_addr",  o_imem_addr,            m_pc);
            check("model_ifpc",  o_if_id_pc,             m_ifpc);
            check("model_instr", o_if_id_instruction,    m_ifi);
            check("model_valid", {31'd0, o_if_id_valid}, {31'd0, m_ifv});
        end
    end

    task automatic applyStimulus(input logic rdy, input logic pw, input logic iw,
                                 input logic br, input logic [31:0] tgt);
        i_imem_ready    = rdy;
        i_pc_write      = pw;
        i_if_id_write   = iw;
        i_branch_taken  = br;
        i_branch_target = tgt;
        @(negedge i_clk);
    endtask

    task automatic checkOutput(input string name, input logic req, input logic [31:0] addr,
                               input logic [31:0] ifpc, input logic [31:0] instr, input logic vld);
        check({name, "_req"},   {31'd0, o_imem_req},    {31'd0, req});
        check({name, "_addr"},  o_imem_addr,            addr);
        check({name, "_ifpc"},  o_if_id_pc,             ifpc);
        check({name, "_instr"}, o_if_id_instruction,    instr);
        check({name, "_valid"}, {31'd0, o_if_id_valid}, {31'd0, vld});
    endtask

    logic        tbl_rdy [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        tbl_adv [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        tbl_br  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] tbl_tgt [8] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h0000_002A, 32'd0};

    initial begin
        i_reset         = 1'b1;
        i_imem_ready    = 1'b1;
        i_pc_write      = 1'b1;
        i_if_id_write   = 1'b1;
        i_branch_taken  = 1'b0;
        i_branch_target = 32'd0;
        @(negedge i_clk);
        checkOutput("reset", 1'b0, 32'h0, 32'h0, NOP, 1'b0);
        i_reset = 1'b0;

        // Clean streaming from reset.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        checkOutput("req_rise", 1'b1, 32'h0, 32'h0, NOP, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        checkOutput("stream0", 1'b1, 32'h4, 32'h0, 32'hA5A5_0000, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        checkOutput("stream4", 1'b1, 32'h8, 32'h4, 32'hA5A5_0004, 1'b1);

        // Memory not ready for three cycles at PC=8.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
            checkOutput("bubble8", 1'b1, 32'h8, 32'h8, NOP, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        checkOutput("after_bubble", 1'b1, 32'hC, 32'h8, 32'hA5A5_0008, 1'b1);

        // Word for PC=12 returns during a two-cycle stall.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("hold1", 1'b0, 32'hC, 32'h8, 32'hA5A5_0008, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("hold2", 1'b0, 32'hC, 32'h8, 32'hA5A5_0008, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        checkOutput("hold_release", 1'b1, 32'h10, 32'hC, 32'hA5A5_000C, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        checkOutput("stream16", 1'b1, 32'h14, 32'h10, 32'hA5A5_0010, 1'b1);

        // Branch during a stall with a buffered word: word dropped, target aligned.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0103);
        checkOutput("branch_stall", 1'b1, 32'h100, 32'h100, NOP, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        checkOutput("after_branch", 1'b1, 32'h104, 32'h100, 32'hA5A5_0100, 1'b1);

        // Branch coinciding with a ready response, then PC wrap.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        checkOutput("branch_ready", 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, NOP, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        checkOutput("wrap", 1'b1, 32'h0, 32'hFFFF_FFFC, 32'h5A5A_FFFC, 1'b1);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(tbl_rdy[i], tbl_adv[i], tbl_adv[i], tbl_br[i], tbl_tgt[i]);
        end

        // Asynchronous reset while waiting on memory at PC=0x40.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0040);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        checkOutput("pre_reset", 1'b1, 32'h40, 32'h40, NOP, 1'b0);
        #2;
        i_reset = 1'b1;
        #1;
        checkOutput("async_reset", 1'b0, 32'h0, 32'h0, NOP, 1'b0);
        @(negedge i_clk);
        i_reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        checkOutput("post_reset_req", 1'b1, 32'h0, 32'h0, NOP, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        checkOutput("post_reset_fetch", 1'b1, 32'h4, 32'h0, 32'hA5A5_0000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the bubble instruction (addi x0,x0,0).
REQ-003 SHALL have port i_clk  in  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_reset  in  1  meaning the asynchronous, active-high reset.
REQ-005 SHALL have port i_pc_write  in  1  meaning hazard-unit PC enable; 0 holds the PC.
REQ-006 SHALL have port i_if_id_write  in  1  meaning hazard-unit IF/ID enable; 0 holds the IF/ID outputs.
REQ-007 SHALL have port i_branch_taken  in  1  meaning redirect request from EX.
REQ-008 SHALL have port i_branch_target  in  32  meaning the redirect address.
REQ-009 SHALL have port o_imem_req  out  1  meaning instruction-memory fetch request.
REQ-010 SHALL have port o_imem_addr  out  32  meaning fetch address, equal to the PC register.
REQ-011 SHALL have port i_imem_ready  in  1  meaning i_imem_rdata is valid for o_imem_addr this cycle.
REQ-012 SHALL have port i_imem_rdata  in  32  meaning the fetched instruction word.
REQ-013 SHALL have ports o_if_id_pc  out  32, o_if_id_instruction  out  32 and o_if_id_valid  out  1, meaning the registered IF/ID pipeline outputs.

Function
REQ-014 SHALL implement FSM states WAIT_RST, FETCH and BUF_HOLD.
REQ-015 SHALL drive o_imem_req=0 in WAIT_RST and BUF_HOLD, and o_imem_req=1 in FETCH.
REQ-016 SHALL keep o_imem_addr stable while o_imem_req=1 and i_imem_ready=0.
REQ-017 SHALL move from WAIT_RST to FETCH unconditionally one cycle after reset deasserts.
REQ-018 SHALL, in FETCH with i_imem_ready=1, i_pc_write=1 and i_if_id_write=1: load IF/ID with {PC, i_imem_rdata, valid=1}, set PC to PC+4 and stay in FETCH, giving 1-cycle latency from accept to IF/ID.
REQ-019 SHALL, in FETCH with i_imem_ready=1 and (i_pc_write=0 or i_if_id_write=0): capture i_imem_rdata into a 32-bit hold buffer, keep PC, and go to BUF_HOLD.
REQ-020 SHALL, in FETCH with i_imem_ready=0 and i_if_id_write=1: load an IF/ID bubble {PC, NOP_INSTR, valid=0}.
REQ-021 SHALL, in BUF_HOLD when i_pc_write=1 and i_if_id_write=1: load IF/ID with {PC, buffer, valid=1}, set PC to PC+4 and go to FETCH.
REQ-022 SHALL hold all IF/ID outputs unchanged in any cycle where i_if_id_write=0 and i_branch_taken=0.
REQ-023 SHALL give i_branch_taken=1 priority over every stall and memory event: PC set to i_branch_target, IF/ID set to {i_branch_target, NOP_INSTR, valid=0}, hold buffer discarded, next state FETCH.
REQ-024 SHALL discard an i_imem_ready response arriving in the same cycle as i_branch_taken=1.
REQ-025 SHALL compute PC+4 modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-026 SHALL force i_branch_target[1:0] to 2'b00 when loading the PC.

Reset
REQ-027 SHALL, while i_reset=1 and independent of i_clk, set: PC=RESET_PC, state=WAIT_RST, o_imem_req=0, o_if_id_pc=0, o_if_id_instruction=NOP_INSTR, o_if_id_valid=0, hold buffer=0.
REQ-028 SHALL abandon any outstanding fetch or buffered word when reset asserts mid-operation, and the first request after reset SHALL use RESET_PC.

Verification
REQ-029 Reset release, i_imem_ready=1 always, rdata=addr^32'hA5A5_0000, no stalls -> req rises 1 cycle after reset; IF/ID yields pc 0,4,8 with matching rdata and valid=1 on consecutive cycles.
REQ-030 i_imem_ready low for 3 cycles at PC=8 -> 3 bubbles {8, 32'h0000_0013, valid=0}, addr held at 8, then {8, rdata, valid=1}.
REQ-031 Word for PC=12 returns while i_pc_write=i_if_id_write=0 for 2 cycles -> BUF_HOLD, req=0, IF/ID frozen; on release, IF/ID={12, buffered word, 1} and the next addr is 16.
REQ-032 i_branch_taken=1, target=32'h0000_0103, during a stall with a buffered word -> PC=32'h100, IF/ID={32'h100, NOP, 0}, buffer dropped, next fetch at 32'h100.
REQ-033 Branch to 32'hFFFF_FFFC then one accepted fetch -> next o_imem_addr=32'h0000_0000.
REQ-034 Assert i_reset in FETCH with ready=0 at PC=32'h40 -> outputs reset immediately, with no clock edge required; after release, the first fetch is at RESET_PC.
